// File: rtl/if_id_stage.sv
// IF/ID pipeline register with load-use stall and branch flush control.
// It exposes its FSM state and saturating stall and flush event counters.
module if_id_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_plus4_if,
    input  logic [31:0] instr_if,
    input  logic        id_ex_mem_read,
    input  logic [4:0]  id_ex_rt,
    input  logic        branch_taken,
    output logic        pc_write,
    output logic [31:0] pc_plus4_id,
    output logic [31:0] instr_id,
    output logic [14:0] reg_addr_id,
    output logic        valid_id,
    output logic        bubble,
    output logic [1:0]  state,
    output logic [15:0] stall_count,
    output logic [15:0] flush_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        STALL = 2'b10,
        FLUSH = 2'b11
    } state_t;

    state_t     cur_state, nxt_state;
    logic       hazard;
    logic       do_load, do_flush, do_stall;
    logic [4:0] rs_id, rt_id;

    assign rs_id       = instr_id[25:21];
    assign rt_id       = instr_id[20:16];
    assign reg_addr_id = {instr_id[25:21], instr_id[20:16], instr_id[15:11]};
    assign state       = cur_state;

    assign hazard = valid_id & id_ex_mem_read & (id_ex_rt != 5'd0) &
                    ((id_ex_rt == rs_id) | (id_ex_rt == rt_id));

    // IDLE always captures the first fetch, whatever the hazard/branch inputs say.
    always_comb begin
        nxt_state = RUN;
        pc_write  = 1'b1;
        bubble    = 1'b0;
        do_load   = 1'b0;
        do_flush  = 1'b0;
        do_stall  = 1'b0;
        if (reset) begin
            nxt_state = IDLE;
            pc_write  = 1'b0;
        end else if (cur_state == IDLE) begin
            do_load = 1'b1;
        end else if (branch_taken) begin
            bubble    = 1'b1;
            do_flush  = 1'b1;
            nxt_state = FLUSH;
        end else if (hazard) begin
            pc_write  = 1'b0;
            bubble    = 1'b1;
            do_stall  = 1'b1;
            nxt_state = STALL;
        end else begin
            do_load = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state   <= IDLE;
            pc_plus4_id <= 32'd0;
            instr_id    <= 32'd0;
            valid_id    <= 1'b0;
            stall_count <= 16'd0;
            flush_count <= 16'd0;
        end else begin
            cur_state <= nxt_state;
            if (do_flush) begin
                pc_plus4_id <= 32'd0;
                instr_id    <= 32'd0;
                valid_id    <= 1'b0;
                if (flush_count != 16'hFFFF) flush_count <= flush_count + 16'd1;
            end else if (do_load) begin
                pc_plus4_id <= pc_plus4_if;
                instr_id    <= instr_if;
                valid_id    <= 1'b1;
            end
            if (do_stall && stall_count != 16'hFFFF) stall_count <= stall_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_if_id_stage.sv
// Directed and randomized checks of if_id_stage against a rule-level model
// of the IF/ID register, stall/flush decisions and saturating counters.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_plus4_if, instr_if;
    logic        id_ex_mem_read, branch_taken;
    logic [4:0]  id_ex_rt;
    logic        pc_write, valid_id, bubble;
    logic [31:0] pc_plus4_id, instr_id;
    logic [14:0] reg_addr_id;
    logic [1:0]  state;
    logic [15:0] stall_count, flush_count;

    int tests = 0;
    int fails = 0;

    // Model of what the ID stage holds.
    logic [31:0] m_pc, m_instr;
    logic        m_valid;
    int          m_stall, m_flush;
    logic [1:0]  m_state;

    localparam logic [31:0] LW_INSTR  = 32'h8C080004;
    localparam logic [31:0] ADD_INSTR = 32'h010A4820; // add $9,$8,$10

    if_id_stage dut (
        .clk(clk), .reset(reset), .pc_plus4_if(pc_plus4_if), .instr_if(instr_if),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
        .pc_write(pc_write), .pc_plus4_id(pc_plus4_id), .instr_id(instr_id),
        .reg_addr_id(reg_addr_id), .valid_id(valid_id), .bubble(bubble), .state(state),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hazard(input logic mr, input logic [4:0] rt);
        logic [4:0] f_rs, f_rt;
        f_rs = m_instr[25:21];
        f_rt = m_instr[20:16];
        return m_valid && mr && rt != 0 && (rt == f_rs || rt == f_rt);
    endfunction

    task automatic model_reset();
        m_pc = 0; m_instr = 0; m_valid = 0; m_stall = 0; m_flush = 0; m_state = 2'b00;
    endtask

    task automatic model_edge(input logic [31:0] pc, input logic [31:0] ins,
                              input logic mr, input logic [4:0] rt, input logic br);
        logic first, hz;
        first = (m_state == 2'b00);
        hz    = model_hazard(mr, rt);
        if (!first && br) begin
            m_pc = 0; m_instr = 0; m_valid = 0; m_state = 2'b11;
            m_flush = (m_flush < 65535) ? m_flush + 1 : 65535;
        end else if (!first && hz) begin
            m_state = 2'b10;
            m_stall = (m_stall < 65535) ? m_stall + 1 : 65535;
        end else begin
            m_pc = pc; m_instr = ins; m_valid = 1; m_state = 2'b01;
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".instr_id"}, instr_id, m_instr);
        chk({tag, ".pc_plus4_id"}, pc_plus4_id, m_pc);
        chk({tag, ".valid_id"}, {31'd0, valid_id}, {31'd0, m_valid});
        chk({tag, ".state"}, {30'd0, state}, {30'd0, m_state});
        chk({tag, ".stall_count"}, {16'd0, stall_count}, m_stall);
        chk({tag, ".flush_count"}, {16'd0, flush_count}, m_flush);
        chk({tag, ".reg_addr_id"}, {17'd0, reg_addr_id},
            {17'd0, m_instr[25:21], m_instr[20:16], m_instr[15:11]});
    endtask

    // One cycle: drive, check combinational controls, clock, check registers.
    task automatic step(input string tag, input logic [31:0] pc, input logic [31:0] ins,
                        input logic mr, input logic [4:0] rt, input logic br);
        logic hz, first, exp_pcw, exp_bub;
        pc_plus4_if = pc; instr_if = ins; id_ex_mem_read = mr; id_ex_rt = rt; branch_taken = br;
        #1;
        first   = (m_state == 2'b00);
        hz      = model_hazard(mr, rt);
        exp_pcw = first || br || !hz;
        exp_bub = !first && (br || hz);
        chk({tag, ".pc_write"}, {31'd0, pc_write}, {31'd0, exp_pcw});
        chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, exp_bub});
        @(posedge clk);
        model_edge(pc, ins, mr, rt, br);
        #1;
        check_regs(tag);
        @(negedge clk);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, ".pc_write"}, {31'd0, pc_write}, 32'd0);
        chk({tag, ".bubble"}, {31'd0, bubble}, 32'd0);
        check_regs(tag);
    endtask

    initial begin
        logic [4:0]  rt_r;
        logic [31:0] ins_r;
        reset = 1'b1;
        pc_plus4_if = 0; instr_if = 0; id_ex_mem_read = 0; id_ex_rt = 0; branch_taken = 0;
        model_reset();
        #2;
        check_reset_vals("reset");
        @(negedge clk);
        reset = 1'b0;

        // Streaming and first capture.
        step("stream_lw", 32'd4, LW_INSTR, 1'b0, 5'd0, 1'b0);
        chk("stream_lw.reg_addr_fixed", {17'd0, reg_addr_id}, {17'd0, 5'd0, 5'd8, 5'd0});
        step("load_add", 32'd8, ADD_INSTR, 1'b0, 5'd0, 1'b0);

        // Load-use stall then release.
        step("stall", 32'd12, 32'h12345678, 1'b1, 5'd8, 1'b0);
        chk("stall.held", instr_id, ADD_INSTR);
        step("stall_release", 32'd12, 32'h12345678, 1'b0, 5'd8, 1'b0);

        // No false stall.
        step("load_add2", 32'd16, ADD_INSTR, 1'b0, 5'd0, 1'b0);
        step("rt_zero", 32'd20, ADD_INSTR, 1'b1, 5'd0, 1'b0);
        step("rt_mismatch", 32'd24, ADD_INSTR, 1'b1, 5'd5, 1'b0);

        // Branch wins over hazard (rt field match).
        step("branch_hazard", 32'd28, 32'hCAFEF00D, 1'b1, 5'd10, 1'b1);
        step("after_flush", 32'd32, ADD_INSTR, 1'b0, 5'd0, 1'b0);

        // Randomized stream.
        for (int i = 0; i < 300; i++) begin
            ins_r = $urandom;
            case ($urandom_range(0, 3))
                0: rt_r = m_instr[25:21];
                1: rt_r = m_instr[20:16];
                2: rt_r = 5'd0;
                default: rt_r = 5'($urandom_range(0, 31));
            endcase
            step("rand", $urandom, ins_r, 1'($urandom_range(0, 1)), rt_r,
                 ($urandom_range(0, 7) == 0));
        end

        // Stall counter saturation.
        step("sat_load", 32'd40, ADD_INSTR, 1'b0, 5'd0, 1'b0);
        pc_plus4_if = 32'd44; instr_if = 32'h0; id_ex_mem_read = 1'b1; id_ex_rt = 5'd8;
        branch_taken = 1'b0;
        for (int i = 0; i < 65537; i++) begin
            @(posedge clk);
            model_edge(32'd44, 32'h0, 1'b1, 5'd8, 1'b0);
        end
        #1;
        check_regs("saturate");
        chk("saturate.ffff", {16'd0, stall_count}, 32'h0000FFFF);
        @(negedge clk);

        // Asynchronous reset in the middle of a stall.
        step("pre_reset_stall", 32'd48, 32'h0, 1'b1, 5'd8, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_reset_vals("async_reset");
        @(negedge clk);
        reset = 1'b0;
        step("restart", 32'd4, LW_INSTR, 1'b0, 5'd0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
IF_ID_STAGE -- requirements
Module: if_id_stage

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset; takes effect immediately, independent of clk.
REQ-003 The block SHALL have port pc_plus4_if, input, 32 bits: PC+4 of the instruction being fetched.
REQ-004 The block SHALL have port instr_if, input, 32 bits: fetched instruction word.
REQ-005 The block SHALL have port id_ex_mem_read, input, 1 bit: MemRead of the instruction currently in ID/EX.
REQ-006 The block SHALL have port id_ex_rt, input, 5 bits: rt (load destination) of the instruction in ID/EX.
REQ-007 The block SHALL have port branch_taken, input, 1 bit: the instruction in EX redirects the PC this cycle.
REQ-008 The block SHALL have port pc_write, output, 1 bit: PC register load enable.
REQ-009 The block SHALL have port pc_plus4_id, output, 32 bits: registered PC+4, which feeds the ID/EX PCplus4 input.
REQ-010 The block SHALL have port instr_id, output, 32 bits: registered instruction word.
REQ-011 The block SHALL have port reg_addr_id, output, 15 bits: {instr_id[25:21], instr_id[20:16], instr_id[15:11]} = {rs, rt, rd}, matching ID/EX regAddresss_in packing.
REQ-012 The block SHALL have port valid_id, output, 1 bit: instr_id holds a real instruction.
REQ-013 The block SHALL have port bubble, output, 1 bit: when 1, the control word entering ID/EX is forced to 10'b0.
REQ-014 The block SHALL have port state, output, 2 bits: FSM state, where IDLE=00, RUN=01, STALL=10, FLUSH=11.
REQ-015 The block SHALL have ports stall_count and flush_count, outputs, 16 bits each: saturating event counters.

Function
REQ-016 hazard SHALL be computed combinationally as: valid_id & id_ex_mem_read & (id_ex_rt != 0) & (id_ex_rt == rs | id_ex_rt == rt), with rs and rt taken from instr_id.
REQ-017 Priority SHALL be: reset > branch_taken > hazard > normal.
REQ-018 Normal (no flush, no hazard): pc_write=1, bubble=0; at the clk edge load pc_plus4_id<=pc_plus4_if, instr_id<=instr_if, valid_id<=1.
REQ-019 Hazard without branch_taken: pc_write=0, bubble=1; IF/ID registers and valid_id SHALL hold; stall_count increments by 1, saturating at 16'hFFFF.
REQ-020 branch_taken (with or without hazard): pc_write=1, bubble=1; at the clk edge instr_id<=0, pc_plus4_id<=0, valid_id<=0; flush_count increments by 1, saturating at 16'hFFFF; stall_count SHALL NOT increment.
REQ-021 FSM transitions, evaluated at each clk edge, SHALL be: IDLE->RUN unconditionally (first fetch captured); any state->FLUSH on branch_taken; any state->STALL on hazard & ~branch_taken; otherwise ->RUN.
REQ-022 In IDLE, valid_id=0, so hazard=0 and bubble=0; pc_write SHALL be 1.
REQ-023 A load-use stall SHALL last exactly one cycle: the bubble clears id_ex_mem_read on the next edge, after which the held instruction proceeds.
REQ-024 Counters SHALL be strictly 16-bit, with no wrap to 0.
REQ-025 reg_addr_id SHALL be a pure combinational slice of instr_id (no extra latency); total IF->ID latency SHALL be 1 cycle.
REQ-026 pc_write and bubble SHALL be combinational from current register state and the inputs, with no registered delay.

Reset
REQ-027 While reset=1: pc_plus4_id=0, instr_id=0, valid_id=0, stall_count=0, flush_count=0, state=IDLE, pc_write=0, bubble=0.
REQ-028 Reset asserted mid-stall or mid-flush SHALL abort that operation immediately; after deassertion the block SHALL restart from IDLE.
REQ-029 The first rising clk edge after reset deassertion SHALL capture pc_plus4_if and instr_if, with the block entering RUN.

Verification
REQ-030 Reset then streaming: release reset, drive instr_if=32'h8C080004, pc_plus4_if=4 -> after 1 edge instr_id=32'h8C080004, valid_id=1, state=RUN, reg_addr_id={5'd0,5'd8,5'd0}.
REQ-031 Load-use stall: instr_id = add $9,$8,$10 (rs=8), id_ex_mem_read=1, id_ex_rt=8 -> pc_write=0, bubble=1, instr_id held 1 cycle, stall_count 0->1, state=STALL; deassert mem_read -> RUN, instr_if loaded.
REQ-032 No false stall: id_ex_rt=0 with mem_read=1, or rt/rs mismatch -> pc_write=1, bubble=0, stall_count unchanged.
REQ-033 Branch during hazard: hazard true and branch_taken=1 -> pc_write=1, bubble=1, next edge instr_id=0, valid_id=0, flush_count=1, stall_count unchanged, state=FLUSH.
REQ-034 Saturation: force 65537 stall cycles -> stall_count=16'hFFFF, with no wrap.
REQ-035 Async reset mid-stall: assert reset between edges during STALL -> all outputs reach REQ-027 values without a clk edge.
